// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: pixel/coordinate widths, frame size,
// the window-fetch state encoding and the 3x3 window bit-offset helper.
package img_pkg;

  localparam int IMG_DW  = 8;
  localparam int IMG_CW  = 16;
  localparam int FRAME_W = 640;
  localparam int FRAME_H = 480;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    SHIFT,
    EMIT,
    DONE
  } fetch_state_t;

  // Bit offset of p[r][c] inside a packed 3x3 window of dw-bit pixels.
  function automatic int win_off(input int r, input int c, input int dw);
    return (3 * r + c) * dw;
  endfunction

endpackage

// File: rtl/sobel_window_fetch_if.sv
// Frame-buffer read port plus the window handshake towards the Sobel kernel.
// The fetch block is the master: it drives addresses and windows.
interface sobel_window_fetch_if
  import img_pkg::*;
#(
  parameter int DW = IMG_DW,
  parameter int CW = IMG_CW
) ();

  logic [CW-1:0]   rd_h;
  logic [CW-1:0]   rd_w;
  logic [DW-1:0]   rd_data;
  logic [9*DW-1:0] win;
  logic [CW-1:0]   win_h;
  logic [CW-1:0]   win_w;
  logic            win_valid;
  logic            win_ready;

  modport master (
    output rd_h, rd_w, win, win_h, win_w, win_valid,
    input  rd_data, win_ready
  );

  modport slave (
    input  rd_h, rd_w, win, win_h, win_w, win_valid,
    output rd_data, win_ready
  );

endinterface

// File: rtl/sobel_window_fetch_tag.sv
// Delay line carrying {valid, row tag} alongside each frame-buffer read so the
// returning byte can be steered into the right column-buffer slot.
module rd_tag_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [1:0] in_tag,
  output logic       out_valid,
  output logic [1:0] out_tag
);

  logic [RD_LAT-1:0] vld_q;
  logic [1:0]        tag_q [RD_LAT];

  // Shift the tag one stage per cycle; reset flushes anything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= 2'd0;
    end else begin
      vld_q[0] <= in_valid;
      tag_q[0] <= in_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_tag   = tag_q[RD_LAT-1];

endmodule

// File: rtl/sobel_window_fetch.sv
// Walks a loaded frame column by column, reading three vertically adjacent
// pixels per column, and emits one 3x3 neighbourhood per interior pixel.
module sobel_window_fetch
  import img_pkg::*;
#(
  parameter int DW     = IMG_DW,
  parameter int CW     = IMG_CW,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 frame_loaded,
  input  logic [CW-1:0]        H,
  input  logic [CW-1:0]        W,
  sobel_window_fetch_if.master bus,
  output logic                 busy,
  output logic                 done
);

  fetch_state_t state_q, state_d;

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [1:0]    k_q, k_d;
  logic [CW-1:0] h_lat, w_lat;
  logic [CW-1:0] rd_h_q, rd_w_q;
  logic [CW-1:0] win_h_q, win_w_q;
  logic [DW-1:0] col_buf [3];
  logic [DW-1:0] pix_q [3][3];
  logic [9*DW-1:0] win_flat;

  logic latch_size;
  logic issue_valid;
  logic do_shift;
  logic set_centre;
  logic tp_valid;
  logic [1:0] tp_tag;

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (issue_valid),
    .in_tag   (k_q),
    .out_valid(tp_valid),
    .out_tag  (tp_tag)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state, scan position and handshake outputs.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    k_d         = k_q;
    latch_size  = 1'b0;
    issue_valid = 1'b0;
    do_shift    = 1'b0;
    set_centre  = 1'b0;
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (start && frame_loaded) begin
          // Busy already in the accepting cycle so the pass is visible at once.
          busy       = 1'b1;
          latch_size = 1'b1;
          if (H < CW'(3) || W < CW'(3)) begin
            state_d = DONE;
          end else begin
            row_d   = CW'(1);
            col_d   = '0;
            k_d     = 2'd0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        issue_valid = 1'b1;
        if (k_q == 2'd2) begin
          k_d     = 2'd0;
          state_d = WAIT;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      WAIT: begin
        // The bottom-row byte is the last to return, so its tag ends the wait.
        if (tp_valid && tp_tag == 2'd2) state_d = SHIFT;
      end
      SHIFT: begin
        do_shift = 1'b1;
        col_d    = col_q + CW'(1);
        k_d      = 2'd0;
        if (col_q >= CW'(2)) begin
          set_centre = 1'b1;
          state_d    = EMIT;
        end else begin
          state_d = ISSUE;
        end
      end
      EMIT: begin
        if (bus.win_ready) begin
          k_d = 2'd0;
          if (col_q == w_lat) begin
            row_d = row_q + CW'(1);
            col_d = '0;
            if (row_q + CW'(1) == h_lat - CW'(1)) state_d = DONE;
            else                                  state_d = ISSUE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scan position, latched frame size, read address, capture and window shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= 2'd0;
      h_lat   <= '0;
      w_lat   <= '0;
      rd_h_q  <= '0;
      rd_w_q  <= '0;
      win_h_q <= '0;
      win_w_q <= '0;
      for (int r = 0; r < 3; r++) begin
        col_buf[r] <= '0;
        for (int c = 0; c < 3; c++) pix_q[r][c] <= '0;
      end
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      k_q   <= k_d;
      if (latch_size) begin
        h_lat <= H;
        w_lat <= W;
      end
      // Address is registered so it is stable for the whole issue slot.
      if (state_d == ISSUE) begin
        rd_h_q <= row_d - CW'(1) + CW'(k_d);
        rd_w_q <= col_d;
      end
      if (tp_valid) col_buf[tp_tag] <= bus.rd_data;
      if (do_shift) begin
        for (int r = 0; r < 3; r++) begin
          pix_q[r][0] <= pix_q[r][1];
          pix_q[r][1] <= pix_q[r][2];
          pix_q[r][2] <= col_buf[r];
        end
      end
      if (set_centre) begin
        win_h_q <= row_q;
        win_w_q <= col_q - CW'(1);
      end
    end
  end

  // Pack the pixel array into the flat window bus, row-major.
  always_comb begin
    win_flat = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win_flat[win_off(r, c, DW) +: DW] = pix_q[r][c];
  end

  assign bus.rd_h      = rd_h_q;
  assign bus.rd_w      = rd_w_q;
  assign bus.win       = win_flat;
  assign bus.win_h     = win_h_q;
  assign bus.win_w     = win_w_q;
  assign bus.win_valid = (state_q == EMIT);

endmodule

// File: tb/tb_sobel_window_fetch.sv
// Scoreboard bench: two fetch instances (read latency 1 and 2) against a
// frame-buffer model with pixel(h,w) = 16h+w.
module tb_sobel_window_fetch;

  typedef struct {
    logic [15:0] h;
    logic [15:0] w;
    logic [71:0] win;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        start1, fl1, busy1, done1;
  logic [15:0] H1, W1;
  logic        start2, fl2, busy2, done2;
  logic [15:0] H2, W2;
  logic [7:0]  d2a;
  logic        startBusy;

  int checks = 0;
  int failures = 0;
  int winCount1 = 0;
  int winCount2 = 0;
  int doneCount1 = 0;
  int doneCount2 = 0;

  exp_t q1[$];
  exp_t q2[$];

  sobel_window_fetch_if #(.DW(8), .CW(16)) bus1 ();
  sobel_window_fetch_if #(.DW(8), .CW(16)) bus2 ();

  sobel_window_fetch #(.DW(8), .CW(16), .RD_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .frame_loaded(fl1),
    .H(H1), .W(W1), .bus(bus1), .busy(busy1), .done(done1)
  );

  sobel_window_fetch #(.DW(8), .CW(16), .RD_LAT(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .frame_loaded(fl2),
    .H(H2), .W(W2), .bus(bus2), .busy(busy2), .done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] pix(input int h, input int w);
    logic [31:0] v;
    v = h * 16 + w;
    return v[7:0];
  endfunction

  function automatic logic [71:0] expWin(input int h, input int w);
    logic [71:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[(3*r+c)*8 +: 8] = pix(h - 1 + r, w - 1 + c);
    return v;
  endfunction

  // Frame buffer model: one register stage for dut1, two for dut2.
  always @(posedge clk) begin
    bus1.rd_data <= pix(int'(bus1.rd_h), int'(bus1.rd_w));
    d2a          <= pix(int'(bus2.rd_h), int'(bus2.rd_w));
    bus2.rd_data <= d2a;
  end

  task automatic checkOutput(input string name, input logic [71:0] actual,
                             input logic [71:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic pushFrame(input int sel, input int hh, input int ww);
    exp_t e;
    for (int h = 1; h <= hh - 2; h++)
      for (int w = 1; w <= ww - 2; w++) begin
        e.h = 16'(h);
        e.w = 16'(w);
        e.win = expWin(h, w);
        if (sel == 1) q1.push_back(e);
        else          q2.push_back(e);
      end
  endtask

  // Monitor: pops the scoreboard on every accepted window and counts done pulses.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus1.win_valid && bus1.win_ready) begin
      winCount1++;
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL dut1_unexpected_window actual=(%0d,%0d) expected=none",
                 bus1.win_h, bus1.win_w);
      end else begin
        e = q1.pop_front();
        checkOutput("dut1_win_h", 72'(bus1.win_h), 72'(e.h));
        checkOutput("dut1_win_w", 72'(bus1.win_w), 72'(e.w));
        checkOutput("dut1_win", bus1.win, e.win);
      end
    end
    if (bus2.win_valid && bus2.win_ready) begin
      winCount2++;
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL dut2_unexpected_window actual=(%0d,%0d) expected=none",
                 bus2.win_h, bus2.win_w);
      end else begin
        e = q2.pop_front();
        checkOutput("dut2_win_h", 72'(bus2.win_h), 72'(e.h));
        checkOutput("dut2_win_w", 72'(bus2.win_w), 72'(e.w));
        checkOutput("dut2_win", bus2.win, e.win);
      end
    end
    if (done1) doneCount1++;
    if (done2) doneCount2++;
  end

  task automatic applyStimulus(input int sel);
    @(posedge clk); #1;
    if (sel == 1) start1 = 1'b1;
    else          start2 = 1'b1;
    @(negedge clk);
    startBusy = (sel == 1) ? busy1 : busy2;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic waitDone(input int sel, input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if ((sel == 1 && done1) || (sel == 2 && done2)) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL %s actual=timeout expected=done_pulse", name);
    end
  endtask

  task automatic waitValid1(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus1.win_valid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL %s actual=timeout expected=win_valid", name);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 72'(busy1), 72'(0));
    checkOutput({tag, "_done"}, 72'(done1), 72'(0));
    checkOutput({tag, "_win_valid"}, 72'(bus1.win_valid), 72'(0));
    checkOutput({tag, "_rd_h"}, 72'(bus1.rd_h), 72'(0));
    checkOutput({tag, "_rd_w"}, 72'(bus1.rd_w), 72'(0));
    checkOutput({tag, "_win"}, bus1.win, 72'(0));
    checkOutput({tag, "_win_h"}, 72'(bus1.win_h), 72'(0));
    checkOutput({tag, "_win_w"}, 72'(bus1.win_w), 72'(0));
  endtask

  initial begin : stimulus
    int wBase, dBase, busyCnt, doneIdx;
    bit rdChanged;
    logic [71:0] w0;
    logic [15:0] wh0, ww0, rh0, rw0;

    reset_n = 1'b0;
    start1 = 1'b0; fl1 = 1'b0; H1 = 16'd4; W1 = 16'd4; bus1.win_ready = 1'b1;
    start2 = 1'b0; fl2 = 1'b0; H2 = 16'd5; W2 = 16'd3; bus2.win_ready = 1'b1;

    // Reset state
    @(negedge clk);
    checkAllZero("reset");
    checkOutput("reset_dut2_busy", 72'(busy2), 72'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 4x4 frame, ready always high
    $display("[TB] 4x4 frame, free-running");
    fl1 = 1'b1;
    pushFrame(1, 4, 4);
    wBase = winCount1; dBase = doneCount1;
    applyStimulus(1);
    checkOutput("t1_busy_on_start", 72'(startBusy), 72'(1));
    waitDone(1, 300, "t1_done");
    checkOutput("t1_busy_with_done", 72'(busy1), 72'(1));
    @(negedge clk);
    checkOutput("t1_busy_after_done", 72'(busy1), 72'(0));
    checkOutput("t1_done_single", 72'(done1), 72'(0));
    repeat (3) @(negedge clk);
    checkOutput("t1_window_count", 72'(winCount1 - wBase), 72'(4));
    checkOutput("t1_done_count", 72'(doneCount1 - dBase), 72'(1));
    checkOutput("t1_queue_empty", 72'(q1.size()), 72'(0));

    // Same frame, first window stalled for 5 cycles
    $display("[TB] 4x4 frame, stall on first window");
    bus1.win_ready = 1'b0;
    pushFrame(1, 4, 4);
    wBase = winCount1;
    applyStimulus(1);
    waitValid1(100, "t2_first_valid");
    w0 = bus1.win; wh0 = bus1.win_h; ww0 = bus1.win_w;
    rh0 = bus1.rd_h; rw0 = bus1.rd_w;
    checkOutput("t2_p00", 72'(w0[7:0]), 72'(8'h00));
    checkOutput("t2_p11", 72'(w0[39:32]), 72'(8'h11));
    checkOutput("t2_p22", 72'(w0[71:64]), 72'(8'h22));
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("t2_valid_held", 72'(bus1.win_valid), 72'(1));
      checkOutput("t2_win_stable", bus1.win, w0);
      checkOutput("t2_centre_stable", 72'({bus1.win_h, bus1.win_w}), 72'({wh0, ww0}));
      checkOutput("t2_rd_stable", 72'({bus1.rd_h, bus1.rd_w}), 72'({rh0, rw0}));
    end
    @(posedge clk); #1;
    bus1.win_ready = 1'b1;
    waitDone(1, 300, "t2_done");
    repeat (3) @(negedge clk);
    checkOutput("t2_window_count", 72'(winCount1 - wBase), 72'(4));
    checkOutput("t2_queue_empty", 72'(q1.size()), 72'(0));

    // Degenerate H=2 frame: no reads, no windows
    $display("[TB] H=2 frame");
    H1 = 16'd2; W1 = 16'(img_pkg::FRAME_W);
    rh0 = bus1.rd_h; rw0 = bus1.rd_w;
    wBase = winCount1; dBase = doneCount1;
    applyStimulus(1);
    busyCnt = startBusy ? 1 : 0;
    doneIdx = -1;
    rdChanged = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (busy1) busyCnt++;
      if (done1 && doneIdx < 0) doneIdx = i;
      if (bus1.rd_h != rh0 || bus1.rd_w != rw0) rdChanged = 1'b1;
    end
    checkOutput("t3_busy_cycles", 72'(busyCnt), 72'(2));
    checkOutput("t3_done_cycle", 72'(doneIdx), 72'(1));
    checkOutput("t3_no_reads", 72'(rdChanged), 72'(0));
    checkOutput("t3_no_windows", 72'(winCount1 - wBase), 72'(0));
    checkOutput("t3_done_count", 72'(doneCount1 - dBase), 72'(1));

    // start without frame_loaded is ignored
    $display("[TB] start without frame_loaded");
    H1 = 16'd4; W1 = 16'd4; fl1 = 1'b0;
    dBase = doneCount1;
    applyStimulus(1);
    busyCnt = startBusy ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy1) busyCnt++;
    end
    checkOutput("t4_busy_never", 72'(busyCnt), 72'(0));
    checkOutput("t4_no_done", 72'(doneCount1 - dBase), 72'(0));
    fl1 = 1'b1;
    pushFrame(1, 4, 4);
    wBase = winCount1;
    applyStimulus(1);
    waitDone(1, 300, "t4_done");
    repeat (3) @(negedge clk);
    checkOutput("t4_window_count", 72'(winCount1 - wBase), 72'(4));

    // RD_LAT=2 instance, 5x3 frame
    $display("[TB] 5x3 frame, read latency 2");
    fl2 = 1'b1;
    pushFrame(2, 5, 3);
    wBase = winCount2; dBase = doneCount2;
    applyStimulus(2);
    waitDone(2, 400, "t5_done");
    repeat (3) @(negedge clk);
    checkOutput("t5_window_count", 72'(winCount2 - wBase), 72'(3));
    checkOutput("t5_done_count", 72'(doneCount2 - dBase), 72'(1));
    checkOutput("t5_queue_empty", 72'(q2.size()), 72'(0));

    // Reset during the second window
    $display("[TB] reset mid-pass");
    bus1.win_ready = 1'b0;
    pushFrame(1, 3, 3);
    dBase = doneCount1;
    applyStimulus(1);
    waitValid1(100, "t6_first_valid");
    @(posedge clk); #1;
    bus1.win_ready = 1'b1;
    @(posedge clk); #1;
    bus1.win_ready = 1'b0;
    waitValid1(100, "t6_second_valid");
    checkOutput("t6_second_centre", 72'({bus1.win_h, bus1.win_w}), 72'({16'd1, 16'd2}));
    #2;
    reset_n = 1'b0;
    #1;
    checkAllZero("t6_async");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("t6_no_done", 72'(doneCount1 - dBase), 72'(0));
    checkOutput("t6_queue_empty", 72'(q1.size()), 72'(0));
    bus1.win_ready = 1'b1;
    pushFrame(1, 4, 4);
    wBase = winCount1;
    applyStimulus(1);
    waitDone(1, 300, "t6_restart_done");
    repeat (3) @(negedge clk);
    checkOutput("t6_restart_windows", 72'(winCount1 - wBase), 72'(4));
    checkOutput("t6_restart_queue_empty", 72'(q1.size()), 72'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_window_fetch.md
Name: sobel_window_fetch

Overview:
- Read-side master for the grayscale frame buffer. After the buffer reports the frame loaded, it walks the frame and issues row/column read coordinates to the buffer's Sobel read port.
- Captures the returned bytes and assembles 3x3 neighbourhoods.
- Presents one window per interior pixel, with the centre coordinates, to the Sobel kernel over a valid/ready handshake.

Parameters:
- DW, 8, pixel width in bits.
- CW, 16, coordinate width; matches the buffer's read_H/read_W ports.
- RD_LAT, 1, cycles from a read address to valid data on rd_data.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a frame pass.
- frame_loaded  in  1  frame buffer holds a complete frame; this is the buffer's all_loaded.
- H  in  CW  frame height in rows.
- W  in  CW  frame width in columns.
- rd_h  out  CW  read row, to buffer read_H.
- rd_w  out  CW  read column, to buffer read_W.
- rd_data  in  DW  buffer read data, valid RD_LAT cycles after the address.
- win  out  9*DW  window; p[r][c] sits at bits [(3r+c)*DW +: DW]; r=0 is the top row, c=0 is the left column.
- win_h  out  CW  centre row of win.
- win_w  out  CW  centre column of win.
- win_valid  out  1  win, win_h and win_w are valid.
- win_ready  in  1  kernel accepts the window.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse when a pass ends.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; every output is 0, including rd_h, rd_w, win, win_h and win_w.
- States: IDLE, ISSUE, WAIT, SHIFT, EMIT, DONE.
- IDLE:
  - Exits only when start=1 and frame_loaded=1; otherwise start is ignored.
  - On start, latches H and W into internal copies. Later changes to H and W do not affect the running pass.
  - If the latched H<3 or W<3, goes to DONE: zero windows, no reads.
  - Otherwise sets row=1, col=0 and goes to ISSUE.
- ISSUE (3 cycles): drives (rd_h,rd_w) = (row-1,col), then (row,col), then (row+1,col), one per cycle. A 2-bit tag travels alongside through an RD_LAT-deep delay line.
- WAIT (RD_LAT cycles): rd_data is captured into col_buf[tag] when the delayed tag is valid. rd_h and rd_w hold their last value.
- SHIFT (1 cycle):
  - The window shifts left one column; col_buf enters column c=2.
  - col increments.
  - If col (before increment) >= 2: win_h=row, win_w=col-1, go to EMIT.
  - Else go to ISSUE.
- EMIT:
  - win_valid=1. win, win_h and win_w hold stable until win_ready=1.
  - On the handshake cycle, win_valid drops the next cycle.
  - If col==W: row increments, col=0, window contents are don't-care. If row then equals H-1, go to DONE; otherwise go to ISSUE.
  - If col<W, go to ISSUE.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in every state except IDLE.
- Window order is row-major. The count is (H-2)*(W-2). Edge pixels are never centres.
- win_ready while win_valid=0 is ignored.
- Address arithmetic is done at CW bits; rd_h/rd_w never exceed H-1/W-1.
- frame_loaded falling mid-pass: the pass still completes.
- Reset mid-pass: immediate abort. There is no done pulse and in-flight read data is discarded.

Decomposition:
- Shared package img_pkg:
  - DW and CW constants.
  - Frame-size constants: 640 and 480.
  - State enum for this FSM.
  - Window index helper constant for (r,c) → bit offset.
- Sub-module rd_tag_pipe: RD_LAT-deep shift register of {valid, 2-bit tag}, driven by the ISSUE cycles.

Test Plan:
- 4x4 frame, pixel(h,w)=16h+w, RD_LAT=1, win_ready tied 1 -> exactly 4 windows, in order (1,1),(1,2),(2,1),(2,2). The first window has p00=0x00, p11=0x11, p22=0x22. done pulses once; busy falls with done.
- Same frame, win_ready=0 for 5 cycles at the first window -> win_valid held high for those cycles; win and win_h/win_w stable; no rd_h/rd_w change while stalled.
- H=2, W=640, start -> no reads, no windows; done one cycle later; busy high for exactly 2 cycles.
- start with frame_loaded=0 -> stays IDLE; busy=0 and no done. Asserting frame_loaded and pulsing start then runs normally.
- RD_LAT=2, 5x3 frame -> windows at centres (1,1),(2,1),(3,1), each with the correct p[r][c] values.
- reset_n pulled low during the 2nd window of a 4x4 pass -> all outputs 0 asynchronously, no done. A new start then yields all 4 windows.
